// File: rtl/num_secuenciador.sv
// num_secuenciador: programmable 4-bit sequence source for DEC_primo.
// Steps num automatically or per debounced press, flagging range wraps.
module num_secuenciador_deb #(
    parameter int DEB_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press
);
    localparam int DW = $clog2(DEB_CYCLES + 1);

    logic          s1;
    logic          s2;
    logic          filt;
    logic [DW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            filt  <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            press <= 1'b0;
            if (s2 == filt) begin
                cnt <= '0;
            end else if (cnt == DW'(DEB_CYCLES - 1)) begin
                // level held long enough: accept it, pulse only on rise
                filt  <= s2;
                cnt   <= '0;
                press <= s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module num_secuenciador #(
    parameter int CLK_DIV    = 50_000_000,
    parameter int DEB_CYCLES = 500_000,
    parameter int N_MIN      = 1,
    parameter int N_MAX      = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_run,
    input  logic       btn_step,
    input  logic       dir,
    output logic [3:0] num,
    output logic       num_stb,
    output logic       wrap,
    output logic       running
);
    localparam int         PW = $clog2(CLK_DIV);
    localparam logic [3:0] LO = 4'(N_MIN);
    localparam logic [3:0] HI = 4'(N_MAX);

    typedef enum logic {
        PAUSA,
        CORRE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_nx;
    logic          press_run;
    logic          press_step;
    logic          dir_s1;
    logic          dir_s2;
    logic          tick;
    logic          adv;
    logic          at_end;
    logic [3:0]    num_nx;

    num_secuenciador_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (btn_run),
        .press(press_run)
    );

    num_secuenciador_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (btn_step),
        .press(press_step)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dir_s1 <= 1'b0;
            dir_s2 <= 1'b0;
        end else begin
            dir_s1 <= dir;
            dir_s2 <= dir_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= PAUSA;
            presc <= '0;
        end else begin
            state <= state_nx;
            presc <= presc_nx;
        end
    end

    always_comb begin
        state_nx = state;
        presc_nx = '0;
        unique case (state)
            PAUSA: begin
                if (press_run) state_nx = CORRE;
            end
            CORRE: begin
                if (press_run) state_nx = PAUSA;
                else if (!tick) presc_nx = presc + 1'b1;
            end
        endcase
    end

    always_comb begin
        tick    = (state == CORRE) && (presc == PW'(CLK_DIV - 1));
        // a run press always wins over a coincident tick or step
        adv     = !press_run && ((state == CORRE) ? tick : press_step);
        at_end  = dir_s2 ? (num == HI) : (num == LO);
        if (at_end) num_nx = dir_s2 ? LO : HI;
        else        num_nx = dir_s2 ? num + 4'd1 : num - 4'd1;
        running = (state == CORRE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            num     <= LO;
            num_stb <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            if (adv) num <= num_nx;
            num_stb <= adv;
            wrap    <= adv && at_end;
        end
    end
endmodule

// File: tb/tb_num_secuenciador.sv
// tb_num_secuenciador: randomized and directed checks of num_secuenciador
// against a cycle-level behavioural model of the sequencer rules.
module tb_num_secuenciador;
    localparam int CLK_DIV = 4;
    localparam int DEB     = 3;
    localparam int N_MIN   = 1;
    localparam int N_MAX   = 15;
    localparam int H       = DEB + 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_run = 1'b0;
    logic       btn_step = 1'b0;
    logic       dir = 1'b1;
    logic [3:0] num;
    logic       num_stb;
    logic       wrap;
    logic       running;

    int errors = 0;
    int checks = 0;

    num_secuenciador #(
        .CLK_DIV   (CLK_DIV),
        .DEB_CYCLES(DEB),
        .N_MIN     (N_MIN),
        .N_MAX     (N_MAX)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_run (btn_run),
        .btn_step(btn_step),
        .dir     (dir),
        .num     (num),
        .num_stb (num_stb),
        .wrap    (wrap),
        .running (running)
    );

    always #5 clk = ~clk;

    // model: raw sample history per input, newest at index 0
    bit         qr[0:H-1];
    bit         qs[0:H-1];
    bit         qd[0:H-1];
    bit         fr, fs, pr, ps, m_run, m_stb, m_wrap;
    int         m_cnt;
    logic [3:0] m_num;
    logic       match;

    assign match = (num === m_num) && (num_stb === m_stb) &&
                   (wrap === m_wrap) && (running === m_run);

    initial forever begin
        bit tick, adv, allr, alls;
        int off, rng;
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < H; i++) begin
                qr[i] = 0; qs[i] = 0; qd[i] = 0;
            end
            fr = 0; fs = 0; pr = 0; ps = 0;
            m_run = 0; m_cnt = 0; m_num = 4'(N_MIN);
            m_stb = 0; m_wrap = 0;
        end else begin
            tick = m_run && ((m_cnt + 1) % CLK_DIV == 0);
            adv  = pr ? 1'b0 : (m_run ? tick : ps);
            m_stb = 0; m_wrap = 0;
            if (adv) begin
                rng = N_MAX - N_MIN + 1;
                off = int'(m_num) - N_MIN;
                if (qd[1]) begin
                    m_wrap = (off == rng - 1);
                    off = (off + 1) % rng;
                end else begin
                    m_wrap = (off == 0);
                    off = (off + rng - 1) % rng;
                end
                m_num = 4'(off + N_MIN);
                m_stb = 1;
            end
            if (pr) begin
                m_run = !m_run; m_cnt = 0;
            end else if (m_run) begin
                m_cnt++;
            end
            // a level is accepted after DEB synced samples disagree with it
            allr = 1; alls = 1;
            for (int i = 1; i <= DEB; i++) begin
                if (qr[i] == fr) allr = 0;
                if (qs[i] == fs) alls = 0;
            end
            pr = 0; ps = 0;
            if (allr) begin fr = !fr; pr = fr; end
            if (alls) begin fs = !fs; ps = fs; end
            for (int i = H - 1; i > 0; i--) begin
                qr[i] = qr[i-1]; qs[i] = qs[i-1]; qd[i] = qd[i-1];
            end
            qr[0] = btn_run; qs[0] = btn_step; qd[0] = dir;
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (num !== 4'd1 || running !== 1'b0 || num_stb !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: num=%0d run=%b stb=%b exp 1 0 0", num, running, num_stb);
            end
            btn_run  = i[0];
            btn_step = ~i[0];
        end
        btn_run = 1'b0; btn_step = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (num !== 4'd1 || running !== 1'b0 || num_stb !== 1'b0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: num=%0d run=%b stb=%b wrap=%b exp 1 0 0 0", num, running, num_stb, wrap);
        end
    endtask

    task automatic test_debounce();
        dir = 1'b1;
        btn_step = 1'b1;
        repeat (2) @(negedge clk);
        btn_step = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (num_stb !== 1'b0 || num !== 4'd1) begin
                errors++;
                $display("FAIL deb_glitch: stb=%b num=%0d exp 0 1", num_stb, num);
            end
        end
        btn_step = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            checks++;
            if (num_stb !== (k == 6) || num !== ((k >= 6) ? 4'd2 : 4'd1)) begin
                errors++;
                $display("FAIL deb_press k=%0d: stb=%b num=%0d exp %b %0d", k, num_stb, num, k == 6, (k >= 6) ? 2 : 1);
            end
        end
        btn_step = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (!match) begin
                errors++;
                $display("FAIL deb_model: num=%0d stb=%b run=%b exp %0d %b %b", num, num_stb, running, m_num, m_stb, m_run);
            end
        end
    endtask

    task automatic test_auto_run();
        logic [3:0] prev;
        int gap, got;
        btn_run = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL run_enter: running=%b exp 1", running);
        end
        btn_run = 1'b0;
        prev = num; gap = 0; got = 0;
        for (int c = 0; c < 200 && got < 15; c++) begin
            @(negedge clk);
            gap++;
            if (num_stb) begin
                checks++;
                if (num !== ((prev == 4'd15) ? 4'd1 : prev + 4'd1) ||
                    wrap !== (prev == 4'd15) || (got > 0 && gap != 4)) begin
                    errors++;
                    $display("FAIL auto_step: num=%0d wrap=%b gap=%0d prev=%0d exp gap 4", num, wrap, gap, prev);
                end
                prev = num; gap = 0; got++;
            end else if (wrap !== 1'b0) begin
                checks++; errors++;
                $display("FAIL auto_wrap: wrap=1 without stb exp 0");
            end
        end
        checks++;
        if (got != 15) begin
            errors++;
            $display("FAIL auto_count: steps=%0d exp 15", got);
        end
    endtask

    task automatic test_down_wrap();
        logic [3:0] want [4] = '{4'd2, 4'd1, 4'd15, 4'd14};
        int got, c;
        for (c = 0; c < 100; c++) begin
            @(negedge clk);
            if (num_stb && num == 4'd3) break;
        end
        checks++;
        if (c == 100) begin
            errors++;
            $display("FAIL down_wait: num=%0d never reached 3", num);
        end
        dir = 1'b0;
        got = 0;
        for (c = 0; c < 100 && got < 4; c++) begin
            @(negedge clk);
            if (num_stb) begin
                checks++;
                if (num !== want[got] || wrap !== (want[got] == 4'd15)) begin
                    errors++;
                    $display("FAIL down_step: num=%0d wrap=%b exp %0d %b", num, wrap, want[got], want[got] == 4'd15);
                end
                got++;
            end
        end
        dir = 1'b1;
        checks++;
        if (got != 4) begin
            errors++;
            $display("FAIL down_count: steps=%0d exp 4", got);
        end
    endtask

    task automatic test_collisions();
        int stbs, c;
        logic [3:0] saved;
        stbs = 0;
        btn_step = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 8) btn_step = 1'b0;
            if (num_stb) stbs++;
            checks++;
            if (!match) begin
                errors++;
                $display("FAIL step_in_run: num=%0d stb=%b exp %0d %b", num, num_stb, m_num, m_stb);
            end
        end
        checks++;
        if (stbs != 3) begin
            errors++;
            $display("FAIL step_in_run_count: stbs=%0d exp 3", stbs);
        end
        for (c = 0; c < 20; c++) begin
            @(negedge clk);
            if (num_stb) break;
        end
        repeat (2) @(negedge clk);
        btn_run = 1'b1;
        saved = num;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 5) saved = num;
        end
        checks++;
        if (running !== 1'b0 || num_stb !== 1'b0 || num !== saved || !match) begin
            errors++;
            $display("FAIL run_tick_collide: run=%b stb=%b num=%0d exp 0 0 %0d", running, num_stb, num, saved);
        end
        btn_run = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (num !== saved || running !== 1'b0) begin
            errors++;
            $display("FAIL paused_hold: num=%0d run=%b exp %0d 0", num, running, saved);
        end
        btn_run = 1'b1; btn_step = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 6) begin
                btn_run = 1'b0; btn_step = 1'b0;
                checks++;
                if (running !== 1'b1 || num !== saved) begin
                    errors++;
                    $display("FAIL run_step_same: run=%b num=%0d exp 1 %0d", running, num, saved);
                end
            end
            checks++;
            if (num_stb !== (k == 10)) begin
                errors++;
                $display("FAIL run_step_stb k=%0d: stb=%b exp %b", k, num_stb, k == 10);
            end
        end
    endtask

    task automatic test_mid_reset();
        int c;
        for (c = 0; c < 100; c++) begin
            @(negedge clk);
            if (num_stb && num == 4'd9) break;
        end
        checks++;
        if (c == 100) begin
            errors++;
            $display("FAIL midrst_wait: num=%0d never reached 9", num);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (num !== 4'd1 || running !== 1'b0) begin
            errors++;
            $display("FAIL midrst: num=%0d run=%b exp 1 0", num, running);
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if (num_stb !== 1'b0 || num !== 4'd1 || running !== 1'b0) begin
                errors++;
                $display("FAIL midrst_idle: stb=%b num=%0d run=%b exp 0 1 0", num_stb, num, running);
            end
        end
    endtask

    task automatic test_random();
        int tr, ts, td, advs;
        tr = 1; ts = 1; td = 1; advs = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            checks++;
            if (!match) begin
                errors++;
                $display("FAIL random c=%0d: num=%0d stb=%b wrap=%b run=%b exp %0d %b %b %b",
                         c, num, num_stb, wrap, running, m_num, m_stb, m_wrap, m_run);
            end
            if (num_stb) advs++;
            rst_n = ($urandom_range(0, 399) != 0);
            if (--tr == 0) begin btn_run  = ~btn_run;  tr = $urandom_range(1, 12); end
            if (--ts == 0) begin btn_step = ~btn_step; ts = $urandom_range(1, 12); end
            if (--td == 0) begin dir = $urandom_range(0, 1); td = $urandom_range(3, 40); end
        end
        rst_n = 1'b1;
        checks++;
        if (advs == 0) begin
            errors++;
            $display("FAIL random_activity: advances=%0d exp >0", advs);
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_auto_run();
        test_down_wrap();
        test_collisions();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/num_secuenciador.md
Name: num_secuenciador

Overview:
- Stimulus source placed directly upstream of the prime decoder (DEC_primo); its 4-bit `num` output drives the decoder's `num` input on the board.
- Steps `num` through a programmable range, either automatically at a prescaled rate or one step per button press.
- Provides debounced run/pause and step buttons, a direction switch, a change strobe and a wrap pulse.
- Replaces the bench-only stimulus with synthesizable hardware so the decoder `led` can be demonstrated on the FPGA.

Parameters:
- CLK_DIV, 50_000_000: clock cycles per automatic step (1 Hz at 50 MHz); must be >= 2.
- DEB_CYCLES, 500_000: consecutive stable cycles required to accept a button level change (10 ms at 50 MHz); must be >= 1.
- N_MIN, 1: lowest sequence value.
- N_MAX, 15: highest sequence value; 0 <= N_MIN <= N_MAX <= 15.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- btn_run  in  1  raw run/pause push button, active high, asynchronous to clk.
- btn_step  in  1  raw single-step push button, active high, asynchronous to clk.
- dir  in  1  slide switch: 1 = count up, 0 = count down; asynchronous.
- num  out  4  current value, to DEC_primo `num`.
- num_stb  out  1  one-cycle pulse in the cycle `num` shows a new value.
- wrap  out  1  one-cycle pulse coincident with `num_stb` when the step crossed a range end.
- running  out  1  1 while in state CORRE.

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - num = N_MIN; num_stb = 0; wrap = 0; running = 0.
  - FSM = PAUSA; prescaler = 0.
  - Synchronizers and debounce counters cleared; filtered button levels = 0.
  - Reset applied mid-operation aborts any pending step or debounce. No output changes on the first clock after release.
- Input conditioning:
  - btn_run, btn_step and dir each pass through a 2-FF synchronizer.
  - Each button has its own debouncer: a counter increments while the synced level differs from the filtered level and clears otherwise. When the count reaches DEB_CYCLES, the filtered level takes the synced level and the counter clears.
  - A filtered 0->1 transition produces a one-cycle press pulse (press_run / press_step). Release produces nothing.
  - A clean press therefore yields its pulse 2 + DEB_CYCLES + 1 cycles after the raw edge. Bounces shorter than DEB_CYCLES cycles produce no pulse.
  - dir is synchronized only and sampled in the cycle the advance happens.
- FSM states:
  - PAUSA:
    - press_run -> CORRE, prescaler cleared to 0.
    - press_step (without press_run) -> one advance, stay in PAUSA.
    - press_run and press_step in the same cycle: run wins, step discarded.
  - CORRE:
    - Prescaler counts 0..CLK_DIV-1. In the cycle it equals CLK_DIV-1, tick = 1, the prescaler returns to 0 and one advance occurs.
    - press_run -> PAUSA, prescaler cleared. If a tick coincides with press_run, no advance.
    - press_step is ignored.
- Advance (registered; num, num_stb and wrap update together at the same edge):
  - dir = 1: num == N_MAX -> num = N_MIN, wrap = 1; else num + 1.
  - dir = 0: num == N_MIN -> num = N_MAX, wrap = 1; else num - 1.
  - N_MIN == N_MAX: num is unchanged, but num_stb = 1 and wrap = 1.
  - num never leaves [N_MIN, N_MAX]. Arithmetic is 4-bit with no carry out.
- num_stb and wrap are 0 in every cycle without an advance.
- running is a registered copy of the FSM state.

Test Plan (bench parameters CLK_DIV = 4, DEB_CYCLES = 3, N_MIN = 1, N_MAX = 15):
- Reset: hold rst_n = 0 for 3 cycles with buttons toggling -> num = 1, running = 0, num_stb = 0 throughout and on the first cycle after release.
- Debounce: btn_step high for 2 cycles, low, then high for 10 cycles in PAUSA, dir = 1 -> no pulse from the 2-cycle glitch; exactly one num_stb, num 1 -> 2, occurring 6 cycles after the held rising edge.
- Auto run: press btn_run, dir = 1 -> running = 1; num_stb every 4 cycles; sequence 2,3,...,15,1 with wrap = 1 only on 15 -> 1; DEC_primo led high for 2,3,5,7,11,13.
- Down wrap: in CORRE set dir = 0 at num = 3 -> 2, 1, 15 (wrap = 1), 14.
- Collisions: in CORRE, arrange the debounced press_run to coincide with a tick -> running = 0, no num_stb, num unchanged; btn_step in CORRE -> no effect; simultaneous run + step press in PAUSA -> CORRE entered, no extra step.
- Mid-run reset: assert rst_n = 0 for one cycle at num = 9 in CORRE -> num = 1, running = 0; no further steps until a new btn_run press.
